// File: rtl/zx_sram_pkg.sv
// zx_sram_pkg: shared types and helpers for the ULA SRAM arbiter slice.
//   sram_state_t     - access sequencer states (IDLE, SETUP, STROBE, HOLD)
//   TURNAROUND       - minimum IDLE cycles between two SRAM transactions
//   MAX_CHANNELS     - widest request vector the helpers handle
//   onehot_to_index  - index of the set bit of a one-hot vector
package zx_sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } sram_state_t;

  // The sequencer always returns through IDLE for one cycle, which gives
  // the data bus one cycle to turn around between masters.
  localparam int TURNAROUND = 1;

  localparam int MAX_CHANNELS = 8;

  // For a one-hot input returns the position of the set bit; all-zero
  // input returns 0.
  function automatic logic [2:0] onehot_to_index(input logic [MAX_CHANNELS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/zx_rr_arbiter.sv
// zx_rr_arbiter: round-robin arbiter with optional fixed priority for bit 0.
//   clk, rst_n  - clock, asynchronous active-low reset
//   req [N]     - request vector
//   advance     - the current grant is being taken; move the pointer
//   gnt [N]     - one-hot grant (combinational from req and pointer)
// With FIXED_PRIO0=1 bit 0 wins whenever it requests and its wins leave the
// pointer untouched, so the other channels keep their rotation order.
module zx_rr_arbiter
  import zx_sram_pkg::*;
#(
  parameter int N           = 3,
  parameter bit FIXED_PRIO0 = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  generate
    if (N == 1) begin : g_single
      // A single master needs no arbitration.
      assign gnt = req;
      logic unused;
      assign unused = ^{clk, rst_n, advance};
    end else begin : g_rr
      localparam int PW = $clog2(N);
      localparam logic [PW-1:0] PTR_RST = FIXED_PRIO0 ? PW'(1) : '0;

      logic [PW-1:0]           ptr;
      logic [PW-1:0]           ptr_next;
      logic [MAX_CHANNELS-1:0] gnt_pad;

      // Search from the pointer upwards with wrap. The loop runs from the
      // farthest offset to the nearest so the nearest requester overrides.
      always_comb begin
        logic [PW:0] sum;
        gnt = '0;
        sum = '0;
        if (FIXED_PRIO0 && req[0]) begin
          gnt[0] = 1'b1;
        end else begin
          for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
            if (req[sum[PW-1:0]]) begin
              gnt = '0;
              gnt[sum[PW-1:0]] = 1'b1;
            end
          end
        end
      end

      always_comb begin
        logic [3:0] nxt;
        gnt_pad        = '0;
        gnt_pad[N-1:0] = gnt;
        nxt = {1'b0, onehot_to_index(gnt_pad)} + 4'd1;
        if (nxt >= 4'(N)) nxt = '0;
        ptr_next = nxt[PW-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr <= PTR_RST;
        end else if (advance && (|gnt) && !(FIXED_PRIO0 && gnt[0])) begin
          ptr <= ptr_next;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/zx_sram_arbiter.sv
// zx_sram_arbiter: N-master arbiter and strobe generator for the shared
// 8-bit asynchronous video SRAM behind the ULA.
//   clk28, rst_n     - 28 MHz clock, asynchronous active-low reset
//   req/we/addr/wdata- per-channel request, direction and packed operands
//   gnt, done, rdata - per-channel grant, completion pulse, read data
//   va, vd_o, vd_oe  - SRAM address, write data, data bus output enable
//   vd_i             - SRAM read data
//   n_vrd, n_vwr     - active-low SRAM read/write strobes
//
// Handshake: a master raises req[i] with we/addr/wdata valid and keeps it
// high until it sees done[i]. we/addr/wdata are captured on the clock edge
// that raises gnt[i]; later changes are ignored. gnt[i] stays high for the
// whole transaction and falls on the same edge that raises the one-cycle
// done[i] pulse. A transaction, once granted, always completes even if req
// is withdrawn. rdata is valid in the done cycle and held until the next
// read completes.
module zx_sram_arbiter
  import zx_sram_pkg::*;
#(
  parameter int CHANNELS      = 3,
  parameter int AW            = 19,
  parameter int DW            = 8,
  parameter int ACCESS_CYCLES = 2,
  parameter bit FIXED_PRIO0   = 1'b1
) (
  input  logic                   clk28,
  input  logic                   rst_n,
  input  logic [CHANNELS-1:0]    req,
  input  logic [CHANNELS-1:0]    we,
  input  logic [CHANNELS*AW-1:0] addr,
  input  logic [CHANNELS*DW-1:0] wdata,
  output logic [CHANNELS-1:0]    gnt,
  output logic [CHANNELS-1:0]    done,
  output logic [DW-1:0]          rdata,
  output logic [AW-1:0]          va,
  output logic [DW-1:0]          vd_o,
  output logic                   vd_oe,
  input  logic [DW-1:0]          vd_i,
  output logic                   n_vrd,
  output logic                   n_vwr
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

  sram_state_t         state;
  logic [CW-1:0]       cnt;
  logic                is_wr;
  logic [CHANNELS-1:0] arb_gnt;
  logic                arb_advance;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_wdata;
  logic                sel_we;

  assign arb_advance = (state == IDLE) && (|req);

  zx_rr_arbiter #(
    .N           (CHANNELS),
    .FIXED_PRIO0 (FIXED_PRIO0)
  ) u_arb (
    .clk     (clk28),
    .rst_n   (rst_n),
    .req     (req),
    .advance (arb_advance),
    .gnt     (arb_gnt)
  );

  // Operand mux driven by the one-hot arbiter result.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (arb_gnt[i]) begin
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
        sel_we    = we[i];
      end
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      is_wr <= 1'b0;
      gnt   <= '0;
      done  <= '0;
      rdata <= '0;
      va    <= '0;
      vd_o  <= '0;
      vd_oe <= 1'b0;
      n_vrd <= 1'b1;
      n_vwr <= 1'b1;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= arb_gnt;
            va    <= sel_addr;
            vd_o  <= sel_wdata;
            is_wr <= sel_we;
            cnt   <= '0;
            if (sel_we) begin
              // Drive the bus one cycle ahead of the write strobe.
              vd_oe <= 1'b1;
              state <= SETUP;
            end else begin
              n_vrd <= 1'b0;
              state <= STROBE;
            end
          end
        end
        SETUP: begin
          n_vwr <= 1'b0;
          state <= STROBE;
        end
        STROBE: begin
          if (cnt == CNT_LAST) begin
            n_vrd <= 1'b1;
            n_vwr <= 1'b1;
            if (!is_wr) rdata <= vd_i;
            state <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          // va/vd_o stay put through this cycle for SRAM write hold time.
          done  <= gnt;
          gnt   <= '0;
          vd_oe <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/zx_sram_arbiter.md
Name: zx_sram_arbiter

Overview:
- Parametrised N-channel arbiter and timing generator for the shared 8-bit asynchronous SRAM behind the ULA (va/vd/n_vrd/n_vwr).
- Replaces ad-hoc single-master strobe logic. Video fetch, CPU and auxiliary masters (e.g. DMA, SD) each present a request; the block serialises them and drives SRAM strobes with a programmable access width.
- Timing is sized for 55 ns parts at 28 MHz.

Parameters:
- CHANNELS, 3, number of masters (2..8); channel 0 is the video fetch channel
- AW, 19, SRAM address width
- DW, 8, SRAM data width
- ACCESS_CYCLES, 2, clk28 cycles the n_vrd/n_vwr strobe is held low (>=1)
- FIXED_PRIO0, 1, 1: channel 0 always wins; 0: channel 0 joins round-robin

Ports:
- clk28  in  1  system clock, 28 MHz
- rst_n  in  1  asynchronous active-low reset
- req  in  CHANNELS  per-channel request level, held until done
- we  in  CHANNELS  per-channel 1=write, 0=read; sampled at grant
- addr  in  CHANNELS*AW  packed per-channel address, channel i at [i*AW +: AW]
- wdata  in  CHANNELS*DW  packed per-channel write data
- gnt  out  CHANNELS  one-hot, high for the whole transaction of the granted channel
- done  out  CHANNELS  one-hot one-cycle pulse at transaction end
- rdata  out  DW  read data, valid in the done cycle, held until next read completes
- va  out  AW  SRAM address
- vd_o  out  DW  SRAM write data
- vd_oe  out  1  SRAM data bus output enable
- vd_i  in  DW  SRAM read data
- n_vrd  out  1  SRAM read strobe, active low
- n_vwr  out  1  SRAM write strobe, active low

Behaviour:
- Clock and reset: one clock (clk28); reset is asynchronous, active-low (rst_n).
- Reset values: gnt=0, done=0, rdata=0, va=0, vd_o=0, vd_oe=0, n_vrd=1, n_vwr=1, state=IDLE, round-robin pointer=1 (or 0 if FIXED_PRIO0=0).
- Reset mid-transaction aborts immediately and asynchronously: strobes high, vd_oe low, no done pulse.
- All outputs are registered; there are no combinational paths from req to strobes.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: if any req, select winner, register gnt/va/vd_o from the winner, and latch the we bit. Read -> STROBE with n_vrd=0. Write -> SETUP with vd_oe=1, strobes high.
  - SETUP (write only, 1 cycle): address/data settle; -> STROBE with n_vwr=0.
  - STROBE: strobe low for exactly ACCESS_CYCLES cycles (counter). On the last cycle of a read, capture vd_i into rdata. -> HOLD.
  - HOLD (1 cycle): strobes high; va, vd_o and vd_oe unchanged (write hold time). done[winner]=1 and gnt dropped at the end of this cycle. -> IDLE.
- Latency from req seen in IDLE to done pulse:
  - Read: ACCESS_CYCLES+1 cycles after the grant edge.
  - Write: ACCESS_CYCLES+2 cycles after the grant edge.
- Back-to-back: IDLE lasts 1 cycle minimum between transactions (bus turnaround), so a read costs ACCESS_CYCLES+2 cycles per access.
- Arbitration:
  - FIXED_PRIO0=1: ch0 wins whenever it requests. Otherwise the round-robin search starts at the pointer over channels 1..CHANNELS-1; the pointer moves to winner+1 with wrap.
  - FIXED_PRIO0=0: round-robin over all channels.
  - Starvation bound for a non-zero channel with ch0 idle: CHANNELS-2 foreign grants.
- req deasserted while granted: the transaction still completes and done still pulses; the requester ignores it.
- addr/we/wdata changing after grant has no effect (captured at grant).
- Simultaneous req from all channels: exactly one gnt bit; never two.
- Address width: va = selected addr slice, no truncation. CHANNELS=1 degenerates to a single master with no arbitration logic.

Decomposition:
- Package zx_sram_pkg: FSM state enum, constant TURNAROUND=1, function onehot-to-index.
- Sub-module zx_rr_arbiter (parametrised request vector, optional fixed-priority bit 0, pointer register, one-hot grant output), reused later by the port-decode mux.

Test Plan:
- Single read: ch1 req, we=0, addr=0x12345, SRAM model returns 0xA5 after 55 ns, ACCESS_CYCLES=2 -> n_vrd low exactly 2 cycles, va=0x12345, done[1] 3 cycles after grant, rdata=0xA5.
- Single write: ch2 writes 0x3C to 0x00100 -> vd_oe one cycle before n_vwr falls; n_vwr low 2 cycles; va/vd_o stable one cycle after n_vwr rises; readback returns 0x3C.
- Priority: ch0, ch1 and ch2 all request continuously, FIXED_PRIO0=1 -> ch0 granted every transaction. Drop ch0 -> grants alternate 1,2,1,2.
- Round-robin: FIXED_PRIO0=0, CHANNELS=4, all requesting -> grant order 0,1,2,3,0 with one IDLE cycle between each.
- Abort: assert rst_n=0 during the STROBE state of a write -> n_vwr=1 and vd_oe=0 within the same cycle, no done pulse; after release, the next req is serviced normally.
- Early withdraw: ch1 drops req one cycle after gnt[1] -> transaction completes, done[1] pulses once, no regrant to ch1.
